// File: rtl/radar_pulse_sequencer_if.sv
// Serial control bus carrying register writes into the pulse sequencer.
//   saddr    : 7-bit register address
//   sdata    : 32-bit write data
//   s_strobe : one-cycle write strobe, address/data valid while high
// master drives the bus (controller / testbench); slave receives it (sequencer).
interface radar_pulse_sequencer_if;
  logic [6:0]  saddr;
  logic [31:0] sdata;
  logic        s_strobe;

  modport master (output saddr, output sdata, output s_strobe);
  modport slave  (input  saddr, input  sdata, input  s_strobe);
endinterface

// File: rtl/radar_pulse_sequencer.sv
// PRI timing engine: generates per-PRI transmit/receive windows, T/R switch
// control with guard times, DAC and receive sample strobes and a transmit
// side select. Configuration is written over the serial bus into staging
// registers and copied into the active set only at PRI starts, so a PRI
// always runs with one consistent configuration.
//
// Ports
//   clk_i        master clock
//   rst_n_i      asynchronous active-low reset
//   sbus         serial register bus (slave side)
//   tx_ena_o     RF transmit mixer enable
//   trsw_o       T/R switch, 1 = antenna on TX path
//   tx_strobe_o  DAC sample strobe (coincident with tx_ena_o)
//   rx_strobe_o  receive sample strobe, decimated by D
//   side_o       active transmit side
//   pri_start_o  one-cycle pulse at the start of each PRI
//   pulse_cnt_o  PRIs started since enable
//   busy_o       sequencer running
//
// Register map (offsets from BASE_ADDR, write-only)
//   +0 CTRL  bit0 enable (immediate), bit1 round-robin, bits[7:4] fixed side
//   +1 PRI   period in cycles, values 0 and 1 behave as 2
//   +2 TON   transmit length
//   +3 GUARD T/R guard length before and after transmit
//   +4 RXLEN receive window length
//   +5 DECIM receive decimation, D = DECIM[15:0] + 1
module radar_pulse_sequencer #(
  parameter logic [6:0] BASE_ADDR = 7'd64,
  parameter int         NSIDES    = 2,
  parameter int         CNT_W     = 16,
  localparam int        SIDE_W    = (NSIDES > 2) ? $clog2(NSIDES) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  radar_pulse_sequencer_if.slave    sbus,
  output logic                      tx_ena_o,
  output logic                      trsw_o,
  output logic                      tx_strobe_o,
  output logic                      rx_strobe_o,
  output logic [SIDE_W-1:0]         side_o,
  output logic                      pri_start_o,
  output logic [CNT_W-1:0]          pulse_cnt_o,
  output logic                      busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_TX    = 3'd2,
    ST_TRAIL = 3'd3,
    ST_RX    = 3'd4,
    ST_WAIT  = 3'd5
  } state_e;

  // Fixed-side request clamped into the legal side range.
  function automatic logic [SIDE_W-1:0] clamp_side(input logic [3:0] req);
    logic [SIDE_W-1:0] res;
    if ({1'b0, req} >= 5'(NSIDES)) begin
      res = SIDE_W'(NSIDES - 1);
    end else begin
      res = SIDE_W'(req);
    end
    return res;
  endfunction

  // Round-robin successor, wrapping NSIDES-1 back to 0.
  function automatic logic [SIDE_W-1:0] next_side(input logic [SIDE_W-1:0] cur);
    logic [SIDE_W-1:0] res;
    if (cur >= SIDE_W'(NSIDES - 1)) begin
      res = '0;
    end else begin
      res = cur + SIDE_W'(1);
    end
    return res;
  endfunction

  // Sequencer state
  state_e              state_q, state_d;
  logic                en_q, en_d;
  logic [31:0]         c_q, c_d;
  logic [15:0]         rx_ph_q, rx_ph_d;
  logic [SIDE_W-1:0]   side_q, side_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Staging registers (bus-visible)
  logic                stg_rr_q, stg_rr_d;
  logic [3:0]          stg_side_q, stg_side_d;
  logic [31:0]         stg_pri_q, stg_pri_d;
  logic [31:0]         stg_ton_q, stg_ton_d;
  logic [31:0]         stg_guard_q, stg_guard_d;
  logic [31:0]         stg_rxlen_q, stg_rxlen_d;
  logic [15:0]         stg_decim_q, stg_decim_d;

  // Active registers (used by the running PRI)
  logic                act_rr_q, act_rr_d;
  logic [3:0]          act_side_q, act_side_d;
  logic [31:0]         act_pri_q, act_pri_d;
  logic [31:0]         act_ton_q, act_ton_d;
  logic [31:0]         act_guard_q, act_guard_d;
  logic [31:0]         act_rxlen_q, act_rxlen_d;
  logic [15:0]         act_decim_q, act_decim_d;

  // Registered outputs
  logic tx_ena_q, tx_ena_d;
  logic trsw_q, trsw_d;
  logic tx_strobe_q, tx_strobe_d;
  logic rx_strobe_q, rx_strobe_d;
  logic pri_start_q, pri_start_d;
  logic busy_q, busy_d;

  // Bus decode and control events
  logic [6:0]  wr_idx_s;
  logic        wr_s, ctrl_wr_s, start_s, stop_s, wrap_s;
  logic [31:0] pri_last_s;
  logic [33:0] c_ext_s, b_tx_s, b_trail_s, b_rx_s, b_wait_s;

  assign wr_idx_s  = sbus.saddr - BASE_ADDR;
  assign wr_s      = sbus.s_strobe && (sbus.saddr >= BASE_ADDR) && (wr_idx_s <= 7'd5);
  assign ctrl_wr_s = wr_s && (wr_idx_s == 7'd0);
  assign start_s   = ctrl_wr_s && sbus.sdata[0] && !en_q;
  assign stop_s    = ctrl_wr_s && !sbus.sdata[0];

  // PRI values 0 and 1 behave as a 2-cycle period, so the last count is 1.
  assign pri_last_s = (act_pri_q < 32'd2) ? 32'd1 : (act_pri_q - 32'd1);
  assign wrap_s     = en_q && !stop_s && (c_q >= pri_last_s);

  // Window boundaries in 34 bits so 2*GUARD+TON+RXLEN cannot overflow.
  assign c_ext_s   = {2'b00, c_d};
  assign b_tx_s    = {2'b00, act_guard_d};
  assign b_trail_s = b_tx_s + {2'b00, act_ton_d};
  assign b_rx_s    = b_trail_s + {2'b00, act_guard_d};
  assign b_wait_s  = b_rx_s + {2'b00, act_rxlen_d};

  // Staging register writes from the serial bus.
  always_comb begin
    stg_rr_d    = stg_rr_q;
    stg_side_d  = stg_side_q;
    stg_pri_d   = stg_pri_q;
    stg_ton_d   = stg_ton_q;
    stg_guard_d = stg_guard_q;
    stg_rxlen_d = stg_rxlen_q;
    stg_decim_d = stg_decim_q;
    if (wr_s) begin
      case (wr_idx_s)
        7'd0: begin
          stg_rr_d   = sbus.sdata[1];
          stg_side_d = sbus.sdata[7:4];
        end
        7'd1:    stg_pri_d   = sbus.sdata;
        7'd2:    stg_ton_d   = sbus.sdata;
        7'd3:    stg_guard_d = sbus.sdata;
        7'd4:    stg_rxlen_d = sbus.sdata;
        7'd5:    stg_decim_d = sbus.sdata[15:0];
        default: stg_rr_d    = stg_rr_q;
      endcase
    end else begin
      stg_rr_d = stg_rr_q;
    end
  end

  // PRI counter, configuration hand-over, side select and pulse count.
  always_comb begin
    en_d        = en_q;
    c_d         = c_q;
    side_d      = side_q;
    cnt_d       = cnt_q;
    pri_start_d = 1'b0;
    act_rr_d    = act_rr_q;
    act_side_d  = act_side_q;
    act_pri_d   = act_pri_q;
    act_ton_d   = act_ton_q;
    act_guard_d = act_guard_q;
    act_rxlen_d = act_rxlen_q;
    act_decim_d = act_decim_q;

    if (ctrl_wr_s) begin
      en_d = sbus.sdata[0];
    end else begin
      en_d = en_q;
    end

    if (start_s) begin
      // The mode bits of the enabling write take effect with it; the other
      // registers come from whatever was staged beforehand.
      act_rr_d    = sbus.sdata[1];
      act_side_d  = sbus.sdata[7:4];
      act_pri_d   = stg_pri_q;
      act_ton_d   = stg_ton_q;
      act_guard_d = stg_guard_q;
      act_rxlen_d = stg_rxlen_q;
      act_decim_d = stg_decim_q;
      side_d      = sbus.sdata[1] ? '0 : clamp_side(sbus.sdata[7:4]);
      cnt_d       = CNT_W'(1);
      c_d         = 32'd0;
      pri_start_d = 1'b1;
    end else if (!en_d) begin
      c_d = 32'd0;
    end else if (wrap_s) begin
      // Uses the staging values from before this cycle's write, so a write
      // coinciding with the wrap lands one PRI later.
      act_rr_d    = stg_rr_q;
      act_side_d  = stg_side_q;
      act_pri_d   = stg_pri_q;
      act_ton_d   = stg_ton_q;
      act_guard_d = stg_guard_q;
      act_rxlen_d = stg_rxlen_q;
      act_decim_d = stg_decim_q;
      side_d      = stg_rr_q ? next_side(side_q) : clamp_side(stg_side_q);
      cnt_d       = cnt_q + CNT_W'(1);
      c_d         = 32'd0;
      pri_start_d = 1'b1;
    end else begin
      c_d = c_q + 32'd1;
    end
    busy_d = en_d;
  end

  // Next state from the next count; zero-length windows fall through.
  always_comb begin
    state_d = ST_IDLE;
    rx_ph_d = 16'd0;
    if (!en_d) begin
      state_d = ST_IDLE;
    end else if (c_ext_s < b_tx_s) begin
      state_d = ST_LEAD;
    end else if (c_ext_s < b_trail_s) begin
      state_d = ST_TX;
    end else if (c_ext_s < b_rx_s) begin
      state_d = ST_TRAIL;
    end else if (c_ext_s < b_wait_s) begin
      state_d = ST_RX;
    end else begin
      state_d = ST_WAIT;
    end

    // Decimation phase restarts on the first RX cycle; strobe at phase 0.
    if (state_d == ST_RX) begin
      if (c_ext_s == b_rx_s) begin
        rx_ph_d = 16'd0;
      end else if (rx_ph_q >= act_decim_d) begin
        rx_ph_d = 16'd0;
      end else begin
        rx_ph_d = rx_ph_q + 16'd1;
      end
    end else begin
      rx_ph_d = 16'd0;
    end
  end

  // Output decode of the next state, registered below.
  always_comb begin
    tx_ena_d    = 1'b0;
    trsw_d      = 1'b0;
    tx_strobe_d = 1'b0;
    rx_strobe_d = 1'b0;
    case (state_d)
      ST_LEAD, ST_TRAIL: trsw_d = 1'b1;
      ST_TX: begin
        trsw_d      = 1'b1;
        tx_ena_d    = 1'b1;
        tx_strobe_d = 1'b1;
      end
      ST_RX:   rx_strobe_d = (rx_ph_d == 16'd0);
      default: trsw_d      = 1'b0;
    endcase
  end

  // State, configuration and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      c_q         <= 32'd0;
      rx_ph_q     <= 16'd0;
      side_q      <= '0;
      cnt_q       <= '0;
      stg_rr_q    <= 1'b0;
      stg_side_q  <= 4'd0;
      stg_pri_q   <= 32'd0;
      stg_ton_q   <= 32'd0;
      stg_guard_q <= 32'd0;
      stg_rxlen_q <= 32'd0;
      stg_decim_q <= 16'd0;
      act_rr_q    <= 1'b0;
      act_side_q  <= 4'd0;
      act_pri_q   <= 32'd0;
      act_ton_q   <= 32'd0;
      act_guard_q <= 32'd0;
      act_rxlen_q <= 32'd0;
      act_decim_q <= 16'd0;
      tx_ena_q    <= 1'b0;
      trsw_q      <= 1'b0;
      tx_strobe_q <= 1'b0;
      rx_strobe_q <= 1'b0;
      pri_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      c_q         <= c_d;
      rx_ph_q     <= rx_ph_d;
      side_q      <= side_d;
      cnt_q       <= cnt_d;
      stg_rr_q    <= stg_rr_d;
      stg_side_q  <= stg_side_d;
      stg_pri_q   <= stg_pri_d;
      stg_ton_q   <= stg_ton_d;
      stg_guard_q <= stg_guard_d;
      stg_rxlen_q <= stg_rxlen_d;
      stg_decim_q <= stg_decim_d;
      act_rr_q    <= act_rr_d;
      act_side_q  <= act_side_d;
      act_pri_q   <= act_pri_d;
      act_ton_q   <= act_ton_d;
      act_guard_q <= act_guard_d;
      act_rxlen_q <= act_rxlen_d;
      act_decim_q <= act_decim_d;
      tx_ena_q    <= tx_ena_d;
      trsw_q      <= trsw_d;
      tx_strobe_q <= tx_strobe_d;
      rx_strobe_q <= rx_strobe_d;
      pri_start_q <= pri_start_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_ena_o    = tx_ena_q;
  assign trsw_o      = trsw_q;
  assign tx_strobe_o = tx_strobe_q;
  assign rx_strobe_o = rx_strobe_q;
  assign side_o      = side_q;
  assign pri_start_o = pri_start_q;
  assign pulse_cnt_o = cnt_q;
  assign busy_o      = busy_q;

endmodule
